// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared widths, default depth and the buffered-store entry record.
package store_buffer_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SB_DEPTH = 4;
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/store_buffer_forward_match.sv
// sb_forward_match: finds the youngest valid entry matching a load address, searching backward from tail-1.
module sb_forward_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW = $clog2(DEPTH)
) (
  input  sb_entry_t         entries_i [DEPTH],
  input  logic [PW-1:0]     tail_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);
  // Oldest slot is visited first so the youngest match (k=0, slot tail-1) wins.
  always_comb begin
    hit_o = 1'b0;
    data_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries_i[tail_i - PW'(k) - 1'b1].valid && entries_i[tail_i - PW'(k) - 1'b1].addr == addr_i) begin
        hit_o = 1'b1;
        data_o = entries_i[tail_i - PW'(k) - 1'b1].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending stores that drains to memory when loads leave the port idle,
// forwarding buffered data to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              stall,
  output logic              empty,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
  sb_entry_t ent_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0] count_q, count_d;
  logic full, enq, drain, hit;
  logic [DATA_W-1:0] fwd_data;
  assign full = count_q == FULL;
  assign enq = cpu_we & ~full;
  // Loads own the memory port; draining only happens on load-free cycles.
  assign drain = ~rst & ~cpu_re & (count_q != '0);
  always_comb begin
    head_d = drain ? head_q + 1'b1 : head_q;
    tail_d = enq ? tail_q + 1'b1 : tail_q;
    count_d = count_q + (PW + 1)'(enq) - (PW + 1)'(drain);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i].valid <= 1'b0;
    end else begin
      if (drain) ent_q[head_q].valid <= 1'b0;
      if (enq) ent_q[tail_q] <= '{valid: 1'b1, addr: cpu_addr, data: cpu_wd};
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  sb_forward_match #(.DEPTH(DEPTH)) u_fwd (
    .entries_i(ent_q),
    .tail_i   (tail_q),
    .addr_i   (cpu_addr),
    .hit_o    (hit),
    .data_o   (fwd_data)
  );
  assign cpu_rd = (hit & ~rst) ? fwd_data : mem_rd;
  assign stall = cpu_we & full & ~rst;
  assign empty = rst | (count_q == '0);
  assign mem_we = drain;
  assign mem_a = cpu_re ? cpu_addr : ent_q[head_q].addr;
  assign mem_wd = ent_q[head_q].data;
endmodule
